pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 18 +
 rtl/pipe_stall_mon.sv | 42 ++++
 rtl/pipe_stage_reg.sv | 129 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the pipeline stage register and its stall monitor.
// This package holds only constants: default widths, the NOP control encoding
// and the zero-register index. It defines no types.
package pipe_stage_reg_pkg;

  localparam int unsigned PC_W            = 32;
  localparam int unsigned DEF_DATA_W      = 96;
  localparam int unsigned DEF_CTRL_W      = 2;
  localparam int unsigned DEF_RD_W        = 5;
  localparam int unsigned DEF_STALL_LIMIT = 16;

  // Control encoding carried by a bubble (NOP) slot.
  localparam int unsigned CTRL_NOP = 0;

  // Architectural zero register; it is never a forwarding source.
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/pipe_stall_mon.sv
// Consecutive-stall monitor.
// Counts the edges on which stall=1 and bubble=0. The count clears on any other
// edge and saturates at STALL_LIMIT. stall_stuck is registered and goes high on
// the edge where the count reaches STALL_LIMIT.
// Ports: clk, rst (sync, active-high), stall, bubble -> stall_stuck.
module pipe_stall_mon
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic bubble,
  output logic stall_stuck
);

  localparam int unsigned CNT_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: advance while stalled, hold at the limit, clear otherwise.
  always_comb begin
    cnt_d = '0;
    if (stall && !bubble) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      stall_stuck <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      stall_stuck <= (cnt_d == LIMIT);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with stall, bubble and forwarding hint.
// The edge priority is rst > bubble > stall > load. A load whose valid_in is low
// clears reg_write and rd so that a dead slot never forwards.
// Ports:
//   clk, rst (sync, active-high), stall, bubble
//   valid_in, pc_in[31:0], data_in[DATA_W], ctrl_in[CTRL_W], rd_in[RD_W],
//   reg_write_in
//   *_out   registered copies of the inputs
//   fwd_en  combinational valid_out & reg_write_out & (rd_out != 0)
//   stall_stuck  registered, consecutive stalls reached STALL_LIMIT
// Optional macro PIPE_PERF_CNT_EN adds two 32-bit wrapping counters:
//   stall_cnt counts edges with stall=1 and bubble=0.
//   bubble_cnt counts edges with bubble=1.
// Other stages (for example MEM_WB) are built from this module by overriding
// its parameters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W      = DEF_DATA_W,
  parameter int unsigned       CTRL_W      = DEF_CTRL_W,
  parameter int unsigned       RD_W        = DEF_RD_W,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
  parameter int unsigned       STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              bubble,
  input  logic              valid_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              reg_write_in,
  output logic              valid_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              reg_write_out,
  output logic              fwd_en,
  output logic              stall_stuck
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  localparam logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(CTRL_NOP);
  localparam logic [RD_W-1:0]   ZERO_RD  = RD_W'(ZERO_REG);

  logic              valid_d;
  logic [PC_W-1:0]   pc_d;
  logic [DATA_W-1:0] data_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [RD_W-1:0]   rd_d;
  logic              reg_write_d;

  // Next contents: a bubble inserts a NOP, a stall holds, otherwise load.
  always_comb begin
    valid_d     = valid_out;
    pc_d        = pc_out;
    data_d      = data_out;
    ctrl_d      = ctrl_out;
    rd_d        = rd_out;
    reg_write_d = reg_write_out;
    if (bubble) begin
      valid_d     = 1'b0;
      pc_d        = '0;
      data_d      = BUBBLE_DATA;
      ctrl_d      = NOP_CTRL;
      rd_d        = ZERO_RD;
      reg_write_d = 1'b0;
    end else if (!stall) begin
      valid_d     = valid_in;
      pc_d        = pc_in;
      data_d      = data_in;
      ctrl_d      = ctrl_in;
      rd_d        = valid_in ? rd_in : ZERO_RD;
      reg_write_d = valid_in & reg_write_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out     <= 1'b0;
      pc_out        <= '0;
      data_out      <= BUBBLE_DATA;
      ctrl_out      <= NOP_CTRL;
      rd_out        <= ZERO_RD;
      reg_write_out <= 1'b0;
    end else begin
      valid_out     <= valid_d;
      pc_out        <= pc_d;
      data_out      <= data_d;
      ctrl_out      <= ctrl_d;
      rd_out        <= rd_d;
      reg_write_out <= reg_write_d;
    end
  end

  // The forwarding unit may only use a live slot that writes a non-zero register.
  assign fwd_en = valid_out & reg_write_out & (rd_out != ZERO_RD);

  pipe_stall_mon #(
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall_mon (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .bubble      (bubble),
    .stall_stuck (stall_stuck)
  );

`ifdef PIPE_PERF_CNT_EN
  // Performance counters; both wrap modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (bubble) bubble_cnt <= bubble_cnt + 32'd1;
      if (stall && !bubble) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (STALL_LIMIT=4, non-zero BUBBLE_DATA).
module tb_pipe_stage_reg;

  localparam int unsigned DW  = 96;
  localparam int unsigned CW  = 2;
  localparam int unsigned RW  = 5;
  localparam int unsigned LIM = 4;
  localparam logic [DW-1:0] BDATA = {32'hDEAD_BEEF, 64'h0};

  logic          clk;
  logic          rst;
  logic          stall;
  logic          bubble;
  logic          valid_in;
  logic [31:0]   pc_in;
  logic [DW-1:0] data_in;
  logic [CW-1:0] ctrl_in;
  logic [RW-1:0] rd_in;
  logic          reg_write_in;
  logic          valid_out;
  logic [31:0]   pc_out;
  logic [DW-1:0] data_out;
  logic [CW-1:0] ctrl_out;
  logic [RW-1:0] rd_out;
  logic          reg_write_out;
  logic          fwd_en;
  logic          stall_stuck;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int unsigned exp_sc = 0;
  int unsigned exp_bc = 0;

  pipe_stage_reg #(
    .DATA_W      (DW),
    .CTRL_W      (CW),
    .RD_W        (RW),
    .BUBBLE_DATA (BDATA),
    .STALL_LIMIT (LIM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .bubble        (bubble),
    .valid_in      (valid_in),
    .pc_in         (pc_in),
    .data_in       (data_in),
    .ctrl_in       (ctrl_in),
    .rd_in         (rd_in),
    .reg_write_in  (reg_write_in),
    .valid_out     (valid_out),
    .pc_out        (pc_out),
    .data_out      (data_out),
    .ctrl_out      (ctrl_out),
    .rd_out        (rd_out),
    .reg_write_out (reg_write_out),
    .fwd_en        (fwd_en),
    .stall_stuck   (stall_stuck)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .bubble_cnt    (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 time unit after it. The perf-counter model is advanced here.
  task automatic tick;
    if (rst) begin
      exp_sc = 0;
      exp_bc = 0;
    end else if (bubble) begin
      exp_bc++;
    end else if (stall) begin
      exp_sc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input logic [RW-1:0] r, input logic w);
    valid_in     = v;
    pc_in        = pc;
    data_in      = d;
    ctrl_in      = c;
    rd_in        = r;
    reg_write_in = w;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; bubble = 1'b0;
    drive(1'b1, 32'h55, 96'h1234, 2'd3, 5'd3, 1'b1);
    tick();
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h exp 0", valid_out); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %0h exp 0", pc_out); end
    checks++; if (data_out !== BDATA) begin errors++; $display("FAIL reset_data: got %0h exp %0h", data_out, BDATA); end
    checks++; if ({ctrl_out, rd_out, reg_write_out} !== 8'h00) begin errors++; $display("FAIL reset_ctrl_rd_rw: got %0h exp 0", {ctrl_out, rd_out, reg_write_out}); end
    checks++; if (fwd_en !== 1'b0) begin errors++; $display("FAIL reset_fwd: got %0h exp 0", fwd_en); end
    checks++; if (stall_stuck !== 1'b0) begin errors++; $display("FAIL reset_stuck: got %0h exp 0", stall_stuck); end
    rst = 1'b0;
  endtask

  task automatic test_load;
    drive(1'b1, 32'h100, 96'hABC, 2'd2, 5'd5, 1'b1);
    tick();
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL load_pc: got %0h exp 100", pc_out); end
    checks++; if (rd_out !== 5'd5) begin errors++; $display("FAIL load_rd: got %0d exp 5", rd_out); end
    checks++; if (fwd_en !== 1'b1) begin errors++; $display("FAIL load_fwd: got %0h exp 1", fwd_en); end
    checks++; if (data_out !== 96'hABC) begin errors++; $display("FAIL load_data: got %0h exp abc", data_out); end
    checks++; if ({valid_out, reg_write_out, ctrl_out} !== 4'b1110) begin errors++; $display("FAIL load_flags: got %0b exp 1110", {valid_out, reg_write_out, ctrl_out}); end
  endtask

  task automatic test_stall;
    drive(1'b1, 32'h104, 96'hDEF, 2'd1, 5'd9, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_out !== 32'h100 || rd_out !== 5'd5 || data_out !== 96'hABC) begin
        errors++; $display("FAIL stall_hold[%0d]: got pc=%0h rd=%0d data=%0h exp pc=100 rd=5 data=abc", i, pc_out, rd_out, data_out);
      end
    end
    checks++; if (stall_stuck !== 1'b0) begin errors++; $display("FAIL stall3_stuck: got %0h exp 0", stall_stuck); end
    stall = 1'b0;
    tick();
    checks++; if (pc_out !== 32'h104 || rd_out !== 5'd9) begin errors++; $display("FAIL stall_release: got pc=%0h rd=%0d exp pc=104 rd=9", pc_out, rd_out); end
  endtask

  task automatic test_invalid_load;
    drive(1'b0, 32'h200, 96'h77, 2'd3, 5'd7, 1'b1);
    tick();
    checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL invalid_rw: got %0h exp 0", reg_write_out); end
    checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL invalid_rd: got %0d exp 0", rd_out); end
    checks++; if (fwd_en !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("FAIL invalid_fwd_valid: got fwd=%0h valid=%0h exp 0 0", fwd_en, valid_out); end
    checks++; if (pc_out !== 32'h200 || ctrl_out !== 2'd3) begin errors++; $display("FAIL invalid_pc_ctrl: got pc=%0h ctrl=%0d exp 200 3", pc_out, ctrl_out); end
  endtask

  task automatic test_fwd_zero_rd;
    drive(1'b1, 32'h204, 96'h1, 2'd1, 5'd0, 1'b1);
    tick();
    checks++; if (fwd_en !== 1'b0 || valid_out !== 1'b1 || reg_write_out !== 1'b1) begin
      errors++; $display("FAIL fwd_rd0: got fwd=%0h valid=%0h rw=%0h exp 0 1 1", fwd_en, valid_out, reg_write_out);
    end
  endtask

  task automatic test_bubble_stall;
    drive(1'b1, 32'h300, 96'h5A5, 2'd2, 5'd12, 1'b1);
    tick();
    checks++; if (fwd_en !== 1'b1) begin errors++; $display("FAIL bub_pre_fwd: got %0h exp 1", fwd_en); end
    drive(1'b1, 32'h304, 96'h999, 2'd3, 5'd13, 1'b1);
    stall = 1'b1; bubble = 1'b1;
    tick();
    checks++; if (valid_out !== 1'b0 || rd_out !== 5'd0 || fwd_en !== 1'b0) begin
      errors++; $display("FAIL bub_valid_rd_fwd: got %0h %0d %0h exp 0 0 0", valid_out, rd_out, fwd_en);
    end
    checks++; if (data_out !== BDATA) begin errors++; $display("FAIL bub_data: got %0h exp %0h", data_out, BDATA); end
    checks++; if (pc_out !== 32'h0 || ctrl_out !== 2'd0 || reg_write_out !== 1'b0) begin
      errors++; $display("FAIL bub_pc_ctrl_rw: got %0h %0d %0h exp 0 0 0", pc_out, ctrl_out, reg_write_out);
    end
    stall = 1'b0; bubble = 1'b0;
  endtask

  task automatic test_stall_stuck;
    drive(1'b1, 32'h400, 96'h40, 2'd1, 5'd6, 1'b1);
    tick();
    stall = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++; if (stall_stuck !== (i >= 4)) begin errors++; $display("FAIL stuck_edge%0d: got %0h exp %0h", i, stall_stuck, (i >= 4)); end
    end
    stall = 1'b0;
    tick();
    checks++; if (stall_stuck !== 1'b0) begin errors++; $display("FAIL stuck_release: got %0h exp 0", stall_stuck); end
    // A bubble during a stall restarts the count.
    stall = 1'b1;
    repeat (3) tick();
    bubble = 1'b1;
    tick();
    bubble = 1'b0;
    repeat (3) tick();
    checks++; if (stall_stuck !== 1'b0) begin errors++; $display("FAIL stuck_bubble_clear: got %0h exp 0", stall_stuck); end
    tick();
    checks++; if (stall_stuck !== 1'b1) begin errors++; $display("FAIL stuck_after_bubble4: got %0h exp 1", stall_stuck); end
    stall = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid_stall;
    drive(1'b1, 32'h500, 96'h50, 2'd2, 5'd8, 1'b1);
    tick();
    stall = 1'b1;
    repeat (5) tick();
    checks++; if (stall_stuck !== 1'b1) begin errors++; $display("FAIL rst_pre_stuck: got %0h exp 1", stall_stuck); end
    rst = 1'b1;
    tick();
    checks++; if (valid_out !== 1'b0 || pc_out !== 32'h0 || rd_out !== 5'd0 || data_out !== BDATA || stall_stuck !== 1'b0) begin
      errors++; $display("FAIL rst_mid_stall: got v=%0h pc=%0h rd=%0d data=%0h stuck=%0h exp v=0 pc=0 rd=0 data=%0h stuck=0",
                         valid_out, pc_out, rd_out, data_out, stall_stuck, BDATA);
    end
`ifdef PIPE_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin errors++; $display("FAIL rst_perf: got %0d %0d exp 0 0", stall_cnt, bubble_cnt); end
`endif
    rst = 1'b0;
    drive(1'b1, 32'h600, 96'h60, 2'd1, 5'd10, 1'b1);
    tick();
    checks++; if (valid_out !== 1'b0 || pc_out !== 32'h0 || stall_stuck !== 1'b0) begin
      errors++; $display("FAIL post_rst_stall: got v=%0h pc=%0h stuck=%0h exp 0 0 0", valid_out, pc_out, stall_stuck);
    end
    stall = 1'b0;
    tick();
    checks++; if (pc_out !== 32'h600 || rd_out !== 5'd10 || fwd_en !== 1'b1) begin
      errors++; $display("FAIL post_rst_load: got pc=%0h rd=%0d fwd=%0h exp 600 10 1", pc_out, rd_out, fwd_en);
    end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf_cnt;
    stall = 1'b1;
    repeat (3) tick();
    bubble = 1'b1;
    repeat (2) tick();
    stall = 1'b0; bubble = 1'b0;
    tick();
    checks++; if (stall_cnt !== exp_sc) begin errors++; $display("FAIL perf_stall_cnt: got %0d exp %0d", stall_cnt, exp_sc); end
    checks++; if (bubble_cnt !== exp_bc) begin errors++; $display("FAIL perf_bubble_cnt: got %0d exp %0d", bubble_cnt, exp_bc); end
  endtask
`endif

  initial begin
    rst = 1'b1; stall = 1'b0; bubble = 1'b0;
    drive(1'b0, 32'h0, '0, '0, '0, 1'b0);
    test_reset();
    test_load();
    test_stall();
    test_invalid_load();
    test_fwd_zero_rd();
    test_bubble_stall();
    test_stall_stuck();
    test_rst_mid_stall();
`ifdef PIPE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
